gmux_seq: RTL and testbench



---
 rtl/gmux_seq.sv | 131 +++++++++++++
 tb/tb_gmux_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmux_seq.sv
// Global clock-mux sequencer: drains the quadrant enables, switches the source
// select, lets it settle, then re-enables, all from one request/handshake port.
module gmux_seq #(
  parameter int NUM_SRC       = 2,
  parameter int NUM_QUAD      = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SEL_W         = $clog2(NUM_SRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic [NUM_QUAD-1:0] req_mask,
  input  logic [NUM_QUAD-1:0] req_vlp,
  output logic [SEL_W-1:0]    ssel,
  output logic [NUM_QUAD-1:0] den,
  output logic [NUM_QUAD-1:0] sen,
  output logic [NUM_QUAD-1:0] dynen,
  output logic [NUM_QUAD-1:0] vlp,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SETTLE
  } state_t;

  localparam logic [4:0]  CNT_INIT = 5'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SRC_LIM  = 32'(NUM_SRC);

  state_t              state;
  logic [4:0]          cnt;
  logic [NUM_QUAD-1:0] en;
  logic [SEL_W-1:0]    sel_q;
  logic [NUM_QUAD-1:0] mask_q;
  logic [NUM_QUAD-1:0] vlp_q;
  logic                sel_chg;

  logic sel_bad;
  logic is_noop;

  always_comb begin
    sel_bad = (32'(req_sel) >= SRC_LIM);
    is_noop = (req_sel == ssel) && (req_mask == en) && ((req_vlp & ~req_mask) == vlp);
  end

  // den, sen and dynen always move together, so one register drives all three.
  assign den   = en;
  assign sen   = en;
  assign dynen = en;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // NOTE: every register below is updated with <= so all of them sample the
  // pre-edge values; mixing in = here would make the order of statements matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      en      <= '0;
      ssel    <= '0;
      vlp     <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      vlp_q   <= '0;
      sel_chg <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (sel_bad) begin
              err <= 1'b1;
            end else if (is_noop) begin
              done <= 1'b1;
            end else begin
              sel_q   <= req_sel;
              mask_q  <= req_mask;
              vlp_q   <= req_vlp & ~req_mask;
              sel_chg <= (req_sel != ssel);
              cnt     <= CNT_INIT;
              state   <= DRAIN;
              // A source switch must drain every quadrant; a mask change only
              // drops the quadrants being removed.
              en      <= (req_sel != ssel) ? '0 : (en & req_mask);
            end
          end
        end

        DRAIN: begin
          if (cnt == 5'd0) begin
            if (sel_chg) begin
              ssel  <= sel_q;
              cnt   <= CNT_INIT;
              state <= SETTLE;
            end else begin
              en    <= mask_q;
              vlp   <= vlp_q;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end

        SETTLE: begin
          if (cnt == 5'd0) begin
            en    <= mask_q;
            vlp   <= vlp_q;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmux_seq.sv
// Self-checking bench for gmux_seq: transaction-level model of the expected
// output timeline per request, plus a monitor on select-vs-enable ordering.
module tb_gmux_seq;

  localparam int NSRC = 4;
  localparam int NQ   = 4;
  localparam int S    = 4;
  localparam int SW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_sel;
  logic [NQ-1:0] req_mask;
  logic [NQ-1:0] req_vlp;
  logic [SW-1:0] ssel;
  logic [NQ-1:0] den, sen, dynen, vlp;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  // Model of the architecturally visible configuration.
  logic [SW-1:0] m_ssel;
  logic [NQ-1:0] m_en;
  logic [NQ-1:0] m_vlp;

  gmux_seq #(
    .NUM_SRC      (NSRC),
    .NUM_QUAD     (NQ),
    .SETTLE_CYCLES(S),
    .SEL_W        (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .req_mask (req_mask),
    .req_vlp  (req_vlp),
    .ssel     (ssel),
    .den      (den),
    .sen      (sen),
    .dynen    (dynen),
    .vlp      (vlp),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Ordering monitor: the select may only move while every quadrant is off.
  logic          mon_en = 1'b0;
  logic          prev_ok = 1'b0;
  logic [SW-1:0] prev_ssel;
  logic [NQ-1:0] prev_den;

  always @(negedge clk) begin
    if (mon_en && !rst && prev_ok) begin
      checks++;
      if (ssel !== prev_ssel && prev_den !== '0) begin
        errors++;
        $display("FAIL ssel_while_enabled: ssel %0h -> %0h with den=%b, required den=0",
                 prev_ssel, ssel, prev_den);
      end
    end
    prev_ok   <= !rst;
    prev_ssel <= ssel;
    prev_den  <= den;
  end

  function automatic logic [22:0] pack(input logic [SW-1:0] s, input logic [NQ-1:0] e,
                                       input logic [NQ-1:0] v, input logic d, input logic x,
                                       input logic b, input logic r);
    return {s, e, e, e, v, d, x, b, r};
  endfunction

  logic [22:0] obs;
  assign obs = {ssel, den, sen, dynen, vlp, done, err, busy, req_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check every cycle until it completes.
  task automatic run_txn(input logic [SW-1:0] sel, input logic [NQ-1:0] mask,
                         input logic [NQ-1:0] v, input string name);
    bit          bad, noop, chg, fin;
    int          len;
    logic [22:0] exp_v;
    logic [NQ-1:0] v_eff;
    v_eff = v & ~mask;
    bad   = (int'(sel) >= NSRC);
    noop  = !bad && sel == m_ssel && mask == m_en && v_eff == m_vlp;
    chg   = (sel != m_ssel);
    len   = (bad || noop) ? 0 : (chg ? 2 * S : S);

    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: req_ready=%b, required 1", name, req_ready);
    end

    req_valid = 1'b1;
    req_sel   = sel;
    req_mask  = mask;
    req_vlp   = v;
    tick();
    req_valid = 1'b0;
    req_sel   = SW'($urandom);
    req_mask  = NQ'($urandom);
    req_vlp   = NQ'($urandom);

    for (int k = 0; k <= len; k++) begin
      if (bad)
        exp_v = pack(m_ssel, m_en, m_vlp, 1'b0, 1'b1, 1'b0, 1'b1);
      else if (noop)
        exp_v = pack(m_ssel, m_en, m_vlp, 1'b1, 1'b0, 1'b0, 1'b1);
      else begin
        fin   = (k == len);
        exp_v = pack((chg && k >= S) ? sel : m_ssel,
                     fin ? mask : (chg ? '0 : (m_en & mask)),
                     fin ? v_eff : m_vlp,
                     fin, 1'b0, !fin, fin);
      end
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s_k%0d: {ssel,den,sen,dynen,vlp,done,err,busy,ready}=%h, required %h",
                 name, k, obs, exp_v);
      end
      if (k < len) tick();
    end

    if (!bad) begin
      m_ssel = sel;
      m_en   = mask;
      m_vlp  = v_eff;
    end

    tick();
    exp_v = pack(m_ssel, m_en, m_vlp, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s_after: outputs=%h, required %h", name, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_sel   = 3'd1;
    req_mask  = 4'hF;
    req_vlp   = 4'h0;
    tick();
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h, required 0 (ready low in reset)", obs);
    end
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b, required 1", req_ready);
    end
    m_ssel = '0;
    m_en   = '0;
    m_vlp  = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_sel_change();
    run_txn(3'd2, 4'b1111, 4'b0000, "sel_change");
  endtask

  task automatic test_mask_only();
    run_txn(3'd2, 4'b0011, 4'b1100, "mask_only");
  endtask

  task automatic test_err();
    run_txn(3'd5, 4'b1010, 4'b0101, "err_sel5");
    run_txn(3'd4, 4'b1111, 4'b0000, "err_sel4");
  endtask

  task automatic test_noop();
    run_txn(m_ssel, m_en, m_vlp, "noop");
  endtask

  task automatic test_random();
    logic [SW-1:0] s;
    logic [NQ-1:0] m, v;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        s = m_ssel;
        m = m_en;
        v = m_vlp | (NQ'($urandom) & m_en);
      end else begin
        s = SW'($urandom_range(0, 7));
        m = NQ'($urandom);
        v = NQ'($urandom);
      end
      run_txn(s, m, v, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] exp_v;
    logic [SW-1:0] s;
    s = (m_ssel == 3'd3) ? 3'd1 : 3'd3;
    req_valid = 1'b1;
    req_sel   = s;
    req_mask  = 4'hF;
    req_vlp   = 4'h0;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: outputs=%h, required 0", obs);
    end
    rst = 1'b0;
    #1;
    m_ssel = '0;
    m_en   = '0;
    m_vlp  = '0;
    exp_v  = pack(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_release: outputs=%h, required %h", obs, exp_v);
    end
    for (int k = 0; k < 2 * S; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_done_%0d: done=%b busy=%b, required 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] a, b, cur;
    bit exp_acc;
    a   = (m_ssel == 3'd1) ? 3'd3 : 3'd1;
    b   = (a == 3'd1) ? 3'd3 : 3'd1;
    cur = a;
    req_valid = 1'b1;
    req_mask  = 4'hF;
    req_vlp   = 4'h0;
    req_sel   = cur;
    for (int c = 0; c < 36; c++) begin
      exp_acc = (c % (2 * S + 1) == 0);
      checks++;
      if (req_ready !== exp_acc) begin
        errors++;
        $display("FAIL b2b_accept_c%0d: req_ready=%b, required %b", c, req_ready, exp_acc);
      end
      if (req_ready === 1'b1) m_ssel = cur;
      tick();
      if (exp_acc) begin
        cur     = (cur == a) ? b : a;
        req_sel = cur;
      end
      checks++;
      if (done !== (c % (2 * S + 1) == 2 * S)) begin
        errors++;
        $display("FAIL b2b_done_c%0d: done=%b, required %b", c, done, (c % (2 * S + 1) == 2 * S));
      end
    end
    req_valid = 1'b0;
    m_en  = 4'hF;
    m_vlp = 4'h0;
    checks++;
    if (ssel !== m_ssel || den !== 4'hF) begin
      errors++;
      $display("FAIL b2b_final: ssel=%0h den=%b, required %0h 1111", ssel, den, m_ssel);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    req_mask  = '0;
    req_vlp   = '0;
    m_ssel    = '0;
    m_en      = '0;
    m_vlp     = '0;
    test_reset();
    test_sel_change();
    test_mask_only();
    test_err();
    test_noop();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_noop();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
